// File: rtl/writeback.sv
// Writeback stage: commits register writes, turns r15 writes into a PC redirect
// and squashes FLUSH_CYCLES slots afterwards. Optional feature: WRITEBACK_RETIRE_COUNT_EN.
module writeback #(
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inbubble,
  input  logic [31:0] pc,
  input  logic [31:0] insn,
  input  logic        write_reg,
  input  logic [3:0]  write_num,
  input  logic [31:0] write_data,
  output logic        rf_we,
  output logic [3:0]  rf_num,
  output logic [31:0] rf_data,
  output logic        jmp,
  output logic [31:0] jmppc,
  output logic        flush,
  output logic        fwd_valid,
  output logic [3:0]  fwd_num,
  output logic [31:0] fwd_data
`ifdef WRITEBACK_RETIRE_COUNT_EN
  ,
  output logic [31:0] retired
`endif
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);
  localparam logic [3:0] PC_REG     = 4'hF;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rf_we_q, rf_we_d;
  logic [3:0]  rf_num_q, rf_num_d;
  logic [31:0] rf_data_q, rf_data_d;
  logic        jmp_q, jmp_d;
  logic [31:0] jmppc_q, jmppc_d;
  logic        fwd_valid_q, fwd_valid_d;
  logic [3:0]  fwd_num_q, fwd_num_d;
  logic [31:0] fwd_data_q, fwd_data_d;

  logic slot_vld;
  logic is_commit;
  logic is_redirect;

  // pc/insn carry no write information; they only mark a slot as retired.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{pc, insn};

  assign slot_vld    = !inbubble && (state_q == RUN);
  assign is_commit   = slot_vld && write_reg && (write_num != PC_REG);
  assign is_redirect = slot_vld && write_reg && (write_num == PC_REG);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rf_we_d     = 1'b0;
    rf_num_d    = rf_num_q;
    rf_data_d   = rf_data_q;
    jmp_d       = 1'b0;
    jmppc_d     = jmppc_q;
    fwd_valid_d = fwd_valid_q;
    fwd_num_d   = fwd_num_q;
    fwd_data_d  = fwd_data_q;

    case (state_q)
      RUN: begin
        if (is_redirect) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q - 4'd1;
        // <= also recovers cleanly if the counter were ever loaded with 0
        if (cnt_q <= 4'd1) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase

    if (is_commit) begin
      rf_we_d     = 1'b1;
      rf_num_d    = write_num;
      rf_data_d   = write_data;
      fwd_valid_d = 1'b1;
      fwd_num_d   = write_num;
      fwd_data_d  = write_data;
    end

    if (is_redirect) begin
      jmp_d   = 1'b1;
      jmppc_d = {write_data[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= 4'd0;
      rf_we_q     <= 1'b0;
      rf_num_q    <= 4'd0;
      rf_data_q   <= 32'd0;
      jmp_q       <= 1'b0;
      jmppc_q     <= 32'd0;
      fwd_valid_q <= 1'b0;
      fwd_num_q   <= 4'd0;
      fwd_data_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rf_we_q     <= rf_we_d;
      rf_num_q    <= rf_num_d;
      rf_data_q   <= rf_data_d;
      jmp_q       <= jmp_d;
      jmppc_q     <= jmppc_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_num_q   <= fwd_num_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_num    = rf_num_q;
  assign rf_data   = rf_data_q;
  assign jmp       = jmp_q;
  assign jmppc     = jmppc_q;
  // flush is the registered state itself, so it rises on the same edge as jmp
  assign flush     = (state_q == FLUSH);
  assign fwd_valid = fwd_valid_q;
  assign fwd_num   = fwd_num_q;
  assign fwd_data  = fwd_data_q;

`ifdef WRITEBACK_RETIRE_COUNT_EN
  logic [31:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (slot_vld) begin
      retired_d = retired_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= 32'd0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_writeback.sv
// Bench for writeback: a reference model pushes expected outputs per driven slot,
// each test pops and compares them one cycle later.
module tb_writeback;

  localparam int FC = 3;

  logic        clk;
  logic        rst;
  logic        inbubble;
  logic [31:0] pc;
  logic [31:0] insn;
  logic        write_reg;
  logic [3:0]  write_num;
  logic [31:0] write_data;
  logic        rf_we;
  logic [3:0]  rf_num;
  logic [31:0] rf_data;
  logic        jmp;
  logic [31:0] jmppc;
  logic        flush;
  logic        fwd_valid;
  logic [3:0]  fwd_num;
  logic [31:0] fwd_data;
`ifdef WRITEBACK_RETIRE_COUNT_EN
  logic [31:0] retired;
`endif

  writeback #(.FLUSH_CYCLES(FC)) dut (
    .clk       (clk),
    .rst       (rst),
    .inbubble  (inbubble),
    .pc        (pc),
    .insn      (insn),
    .write_reg (write_reg),
    .write_num (write_num),
    .write_data(write_data),
    .rf_we     (rf_we),
    .rf_num    (rf_num),
    .rf_data   (rf_data),
    .jmp       (jmp),
    .jmppc     (jmppc),
    .flush     (flush),
    .fwd_valid (fwd_valid),
    .fwd_num   (fwd_num),
    .fwd_data  (fwd_data)
`ifdef WRITEBACK_RETIRE_COUNT_EN
    ,
    .retired   (retired)
`endif
  );

  typedef struct packed {
    logic        rf_we;
    logic [3:0]  rf_num;
    logic [31:0] rf_data;
    logic        jmp;
    logic [31:0] jmppc;
    logic        flush;
    logic        fwd_valid;
    logic [3:0]  fwd_num;
    logic [31:0] fwd_data;
  } outs_t;

  outs_t q_exp[$];
  int total = 0;
  int bad   = 0;

  int          m_cnt;
  logic [31:0] m_jmppc;
  logic        m_fwd_valid;
  logic [3:0]  m_fwd_num;
  logic [31:0] m_fwd_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t sample();
    outs_t s;
    s = {rf_we, rf_num, rf_data, jmp, jmppc, flush, fwd_valid, fwd_num, fwd_data};
    return s;
  endfunction

  // rf_num/rf_data are only meaningful while rf_we is high
  function automatic outs_t fold(input outs_t o);
    outs_t f;
    f = o;
    if (!f.rf_we) begin
      f.rf_num  = 4'd0;
      f.rf_data = 32'd0;
    end
    return f;
  endfunction

  task automatic drive(input logic r, input logic inb, input logic wr,
                       input logic [3:0] num, input logic [31:0] data);
    outs_t e;
    @(negedge clk);
    rst        = r;
    inbubble   = inb;
    write_reg  = wr;
    write_num  = num;
    write_data = data;
    pc         = $urandom;
    insn       = $urandom;
    e = '0;
    if (r) begin
      m_cnt = 0; m_jmppc = '0; m_fwd_valid = 1'b0; m_fwd_num = '0; m_fwd_data = '0;
    end else if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
    end else if (!inb && wr) begin
      if (num != 4'hF) begin
        e.rf_we = 1'b1; e.rf_num = num; e.rf_data = data;
        m_fwd_valid = 1'b1; m_fwd_num = num; m_fwd_data = data;
      end else begin
        e.jmp = 1'b1;
        m_jmppc = {data[31:2], 2'b00};
        m_cnt = FC;
      end
    end
    e.jmppc     = m_jmppc;
    e.flush     = (m_cnt > 0);
    e.fwd_valid = m_fwd_valid;
    e.fwd_num   = m_fwd_num;
    e.fwd_data  = m_fwd_data;
    q_exp.push_back(e);
  endtask

  task automatic test_reset();
    outs_t e, o;
    drive(1'b1, 1'b0, 1'b1, 4'hF, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 1'b1, 4'h5, 32'hCAFE_F00D);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      e = q_exp.pop_front();
      o = sample();
      total++;
      if (fold(o) !== fold(e)) begin
        bad++;
        $display("FAIL reset[%0d]: got %h want %h", i, fold(o), fold(e));
      end
    end
    total++;
    if (rf_num !== 4'd0 || rf_data !== 32'd0) begin
      bad++;
      $display("FAIL reset_rf: got num=%h data=%h want 0/0", rf_num, rf_data);
    end
  endtask

  task automatic test_write();
    logic        inb[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        wr[5]   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0]  num[5]  = '{4'd3, 4'd0, 4'd7, 4'd14, 4'd9};
    logic [31:0] dat[5]  = '{32'h1234_5678, 32'hFFFF_FFFF, 32'h5555_5555,
                             32'h0BAD_CAFE, 32'h0000_0001};
    outs_t e, o;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, inb[i], wr[i], num[i], dat[i]);
      @(posedge clk); #1;
      e = q_exp.pop_front();
      o = sample();
      total++;
      if (fold(o) !== fold(e)) begin
        bad++;
        $display("FAIL write[%0d]: got %h want %h", i, fold(o), fold(e));
      end
    end
  endtask

  task automatic test_redirect();
    logic        wr[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0]  num[6] = '{4'd15, 4'd2, 4'd15, 4'd6, 4'd8, 4'd15};
    logic [31:0] dat[6] = '{32'h0000_100F, 32'h2222_2222, 32'h0000_2003,
                            32'h6666_6666, 32'h8888_8888, 32'hABCD_0007};
    outs_t e, o;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, wr[i], num[i], dat[i]);
      @(posedge clk); #1;
      e = q_exp.pop_front();
      o = sample();
      total++;
      if (fold(o) !== fold(e)) begin
        bad++;
        $display("FAIL redirect[%0d]: got %h want %h", i, fold(o), fold(e));
      end
    end
    for (int i = 0; i < FC; i++) begin
      drive(1'b0, 1'b1, 1'b0, 4'd0, 32'd0);
      @(posedge clk); #1;
      e = q_exp.pop_front();
      o = sample();
      total++;
      if (fold(o) !== fold(e)) begin
        bad++;
        $display("FAIL redirect_drain[%0d]: got %h want %h", i, fold(o), fold(e));
      end
    end
  endtask

  task automatic test_bubble();
    outs_t e, o;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 4'(i + 10), 32'hB0B0_0000 + i);
      @(posedge clk); #1;
      e = q_exp.pop_front();
      o = sample();
      total++;
      if (fold(o) !== fold(e)) begin
        bad++;
        $display("FAIL bubble[%0d]: got %h want %h", i, fold(o), fold(e));
      end
    end
    drive(1'b0, 1'b1, 1'b1, 4'hF, 32'h0000_4000);
    @(posedge clk); #1;
    e = q_exp.pop_front();
    o = sample();
    total++;
    if (fold(o) !== fold(e)) begin
      bad++;
      $display("FAIL bubble_r15: got %h want %h", fold(o), fold(e));
    end
  endtask

  task automatic test_rst_mid_flush();
    logic        r[5]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0]  num[5] = '{4'd15, 4'd1, 4'd15, 4'd4, 4'd4};
    logic [31:0] dat[5] = '{32'h0000_3001, 32'h1111_1111, 32'h0000_5000,
                            32'h4444_0004, 32'h4444_0005};
    outs_t e, o;
    for (int i = 0; i < 5; i++) begin
      drive(r[i], 1'b0, 1'b1, num[i], dat[i]);
      @(posedge clk); #1;
      e = q_exp.pop_front();
      o = sample();
      total++;
      if (fold(o) !== fold(e)) begin
        bad++;
        $display("FAIL rst_mid_flush[%0d]: got %h want %h", i, fold(o), fold(e));
      end
    end
  endtask

  task automatic test_back_to_back();
    outs_t e, o;
    logic [3:0] n;
    for (int i = 0; i < 40; i++) begin
      n = (i < 8) ? 4'd5 : 4'($urandom_range(0, 14));
      drive(1'b0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) != 0), n, $urandom);
      @(posedge clk); #1;
      e = q_exp.pop_front();
      o = sample();
      total++;
      if (fold(o) !== fold(e)) begin
        bad++;
        $display("FAIL back_to_back[%0d]: got %h want %h", i, fold(o), fold(e));
      end
    end
  endtask

`ifdef WRITEBACK_RETIRE_COUNT_EN
  task automatic test_retire();
    outs_t e;
    logic [31:0] before;
    drive(1'b0, 1'b1, 1'b0, 4'd0, 32'd0);
    @(posedge clk); #1;
    e = q_exp.pop_front();
    dut.retired_q = 32'hFFFF_FFFE;
    before = 32'hFFFF_FFFE;
    drive(1'b0, 1'b1, 1'b1, 4'd3, 32'h1);
    @(posedge clk); #1;
    e = q_exp.pop_front();
    total++;
    if (retired !== before) begin
      bad++;
      $display("FAIL retire_bubble: got %h want %h", retired, before);
    end
    drive(1'b0, 1'b0, 1'b0, 4'd3, 32'h1);
    drive(1'b0, 1'b0, 1'b1, 4'd3, 32'h2);
    @(posedge clk); #1;
    e = q_exp.pop_front();
    e = q_exp.pop_front();
    total++;
    if (retired !== 32'h0000_0000) begin
      bad++;
      $display("FAIL retire_wrap: got %h want %h", retired, 32'h0000_0000);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; inbubble = 1'b1; pc = '0; insn = '0;
    write_reg = 1'b0; write_num = '0; write_data = '0;
    m_cnt = 0; m_jmppc = '0; m_fwd_valid = 1'b0; m_fwd_num = '0; m_fwd_data = '0;
    test_reset();
    test_write();
    test_redirect();
    test_bubble();
    test_rst_mid_flush();
    test_back_to_back();
`ifdef WRITEBACK_RETIRE_COUNT_EN
    test_retire();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
